// File: rtl/rv32_alu_logical_arb.sv
// Round-robin arbiter sharing one RV32I logical unit (AND/OR/XOR) between two
// requesters, with a registered one-entry result stage.
module rv32_alu_logical_arb #(
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [63:0]        req_opa,
  input  logic [63:0]        req_opb,
  input  logic [9:0]         req_opsel,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_result,
  output logic               rsp_src,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_illegal
);

  logic             prio;
  logic [1:0]       grant;
  logic             can_load;
  logic             accept;
  logic             sel;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [4:0]       op_sel;
  logic [TAG_W-1:0] op_tag;
  logic [31:0]      alu_result;
  logic             alu_illegal;

  // Grant looks only at req_valid and prio, so req_ready never feeds back into it.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign can_load  = !flush && (!rsp_valid || rsp_ready);
  assign req_ready = (can_load && rst_n) ? grant : 2'b00;
  assign accept    = |req_ready;
  assign sel       = req_ready[1];

  assign op_a   = sel ? req_opa[63:32]          : req_opa[31:0];
  assign op_b   = sel ? req_opb[63:32]          : req_opb[31:0];
  assign op_sel = sel ? req_opsel[9:5]          : req_opsel[4:0];
  assign op_tag = sel ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];

  // Register and immediate encodings of each logical op map to the same function.
  always_comb begin
    alu_result  = 32'd0;
    alu_illegal = 1'b0;
    case (op_sel)
      5'd2, 5'd9:  alu_result = op_a & op_b;
      5'd3, 5'd10: alu_result = op_a | op_b;
      5'd4, 5'd11: alu_result = op_a ^ op_b;
      default:     alu_illegal = 1'b1;
    endcase
  end

  // Acceptance wins over drain, so a simultaneous drain and accept keeps rsp_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_result  <= 32'd0;
      rsp_src     <= 1'b0;
      rsp_tag     <= '0;
      rsp_illegal <= 1'b0;
      prio        <= 1'b0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
      prio      <= 1'b0;
    end else if (accept) begin
      rsp_valid   <= 1'b1;
      rsp_result  <= alu_result;
      rsp_src     <= sel;
      rsp_tag     <= op_tag;
      rsp_illegal <= alu_illegal;
      prio        <= ~sel;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rv32_alu_logical_arb.md
# rv32_alu_logical_arb

Two-requester arbiter and result stage for the RV32I logical ALU (AND/OR/XOR, register and immediate forms). It shares a single logical unit between requester 0 (integer execute stage) and requester 1 (auxiliary unit, e.g. CSR/bit-manip sequencer). Arbitration is round-robin with per-requester valid/ready handshakes. Each result is registered into a one-entry output stage with its own valid/ready handshake, source ID and tag.

## Interface
Parameters:
- TAG_W, 4, width of the per-request tag returned with the result

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of the output stage and arbitration pointer
- req_valid  in  2  bit i = requester i has a request
- req_ready  out  2  bit i = requester i's request accepted this cycle
- req_opa  in  64  operand A; requester i in bits [32i+31:32i]
- req_opb  in  64  operand B (register or immediate already selected); same packing
- req_opsel  in  10  ALU op select; requester i in bits [5i+4:5i]
- req_tag  in  2*TAG_W  requester tag; requester i in bits [TAG_W*i+TAG_W-1:TAG_W*i]
- rsp_valid  out  1  output stage holds a result
- rsp_ready  in  1  consumer takes the result this cycle
- rsp_result  out  32  logical result
- rsp_src  out  1  requester index that produced the result
- rsp_tag  out  TAG_W  tag of that request
- rsp_illegal  out  1  opsel was not a logical op; rsp_result is 0

## Operation
- Op decode, per accepted request:
  - opsel 2 or 9: A & B
  - opsel 3 or 10: A | B
  - opsel 4 or 11: A ^ B
  - any other value: result 0 with rsp_illegal=1
- Output stage can load when `can_load = !flush && (!rsp_valid || rsp_ready)`.
- Priority pointer `prio` (1 bit) names the favoured requester.
  - If both req_valid bits are set, grant prio.
  - If only one is set, grant it.
  - If neither is set, no grant.
- req_ready[i] = grant[i] && can_load. At most one bit is ever set.
- Grant depends only on req_valid and prio. It never depends on req_ready, so there is no combinational loop.
- Requester rules:
  - Hold valid, operands, opsel and tag stable until ready.
  - Valid must not drop before acceptance. The block does not check this.
- On acceptance (req_valid[i] && req_ready[i]):
  - Register result, src=i, tag and illegal flag.
  - Set rsp_valid=1.
  - Set prio = ~i.
- If rsp_valid && rsp_ready and there is no acceptance that cycle, clear rsp_valid.
- Simultaneous drain and accept: the new result overwrites the old one and rsp_valid stays 1.
- prio changes only on an acceptance. A lone requester is therefore served back to back.
- flush:
  - rsp_valid←0 and prio←0.
  - req_ready is forced to 0 that cycle.
  - A result presented with rsp_ready=1 during flush counts as dropped, not delivered.
- Starvation bound: a requester holding valid is accepted within 2 output-stage loads.

## Timing
- Reset (rst_n=0, asynchronous):
  - rsp_valid=0, rsp_result=0, rsp_src=0, rsp_tag=0, rsp_illegal=0, prio=0.
  - req_ready=0 while reset is asserted.
- Reset mid-transfer discards the held result. No response is emitted after release.
- Latency: a request accepted at edge N has rsp_valid=1 in the cycle after edge N, i.e. 1 cycle.
- Throughput: 1 result per cycle while rsp_ready=1.
- With rsp_ready=0 and rsp_valid=1: req_ready=0 and the output holds its value.
- rsp_* are register outputs. req_ready is combinational from req_valid, prio, rsp_valid, rsp_ready and flush.
- Payload registers update only on acceptance. While rsp_valid=0, rsp_result, rsp_src, rsp_tag and rsp_illegal hold their previous values; consumers ignore them when rsp_valid=0.

## Test plan
- Reset then single request: req0 A=0xF0F0_F0F0, B=0x0FF0_0FF0, opsel=2, tag=3 → next cycle rsp_valid=1, result=0x00F0_00F0, src=0, tag=3, illegal=0.
- Op coverage on both requesters: A=0xAAAA_5555, B=0xFFFF_0000, opsel 2/9/3/10/4/11 → results 0xAAAA_0000, 0xFFFF_5555, 0x5555_5555; opsel 0, 5 and 31 → result 0, illegal=1.
- Contention: both valid every cycle, rsp_ready=1 → grants alternate 0,1,0,1 starting with 0 after reset; one rsp per cycle; src alternates.
- Backpressure: rsp_ready=0 for 3 cycles with both valid → req_ready=0 and rsp_* stable. When rsp_ready=1 again, the drain and next accept happen in the same cycle, with no bubble and no lost or duplicated tag.
- Lone requester: only req1 valid for 4 cycles → accepted every cycle, src=1 each time. Then both valid → req0 granted first (prio=0 after a grant to 1).
- Flush and reset: with rsp_valid=1 and both requesting, assert flush → req_ready=0, rsp_valid=0 next cycle, prio=0. Asserting rst_n=0 asynchronously mid-stream → all rsp_* = 0 immediately and no response after release until a new acceptance.
